imem_boot_loader: RTL
=====================

# imem_boot_loader

Boot-time program loader sitting upstream of `cpu_top`. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until the whole image has been written and its checksum verified, then releases the core.

## Interface

Parameters:

- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- `DATA_W`, default 32: instruction word width. The design supports only 32.

Ports:

- `clk` in 1: single clock for all logic.
- `rst` in 1: **asynchronous, active-low reset**.
- `s_valid` in 1: stream byte valid.
- `s_byte` in 8: stream byte.
- `s_ready` out 1: loader can accept a byte. A byte is accepted on a rising edge where `s_valid & s_ready`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_W: write word address.
- `imem_wdata` out 32: write data.
- `core_rst` out 1: active-high reset to `cpu_top`.
- `done` out 1: image loaded and verified. Sticky until reset.
- `err` out 1: load failed. Sticky until reset.

## Operation

Stream format:

- 2-byte word count N, high byte first.
- N words, 4 bytes each, most-significant byte first.
- 1 checksum byte. It equals the mod-256 sum of all 4N word bytes. Header bytes are excluded.

States:

- HDR_HI: capture N[15:8], then go to HDR_LO.
- HDR_LO: capture N[7:0].
  - N > 2^ADDR_W → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA: shift bytes into the word assembler; count bytes 0–3.
  - On the 4th byte: issue a write; word counter +1; byte counter → 0.
  - After word N-1's 4th byte → CSUM.
- CSUM: compare the received byte with the running sum.
  - Equal → DONE.
  - Not equal → ERR.
- DONE: `done`=1, `core_rst`=0.
- ERR: `err`=1, `core_rst`=1.
- DONE and ERR are terminal. Only `rst` leaves them.

Handshake and outputs:

- `s_ready` = 1 exactly in HDR_HI, HDR_LO, DATA and CSUM. It is decoded from state only and never depends on `s_valid`.
- In DONE and ERR `s_ready`=0. Bytes presented there are ignored.
- Running sum is 8 bits, wraps modulo 256. It is cleared on reset.
- `imem_addr` = the word counter value at the time of the write. It never wraps, because N is bounded by the HDR_LO check.
- `imem_wdata` = {b0,b1,b2,b3}, where b0 is the first byte of the word.

Reset behaviour:

- Reset values: state HDR_HI, `s_ready`=0 while `rst`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `done`=0, `err`=0. All counters and the sum are 0.
- Reset asserted mid-load: immediate return to the reset values. `core_rst` rises asynchronously. Memory contents already written are not cleared.

## Timing

- `s_ready` rises in the first cycle after `rst` deasserts.
- Throughput: one byte per cycle when `s_valid` is held high. Gaps in `s_valid` stall the loader with no state change.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid for exactly one cycle, starting the cycle after the edge that accepts a word's 4th byte.
- Consecutive words produce `imem_we` pulses spaced by at least 4 cycles.
- Release: the checksum byte is accepted at edge k.
  - On a match, `done`=1 and `core_rst`=0 from edge k.
  - The last `imem_we` pulse ends no later than edge k, so the write completes before the core leaves reset.
- Errors: `err` rises at the edge that accepts the failing byte (HDR_LO or CSUM). `s_ready` is 0 from that edge on.
- Minimum load time for N words: 4N+3 accepted bytes.

## Test plan

1. **Three-word load.** Stream 00 03, 20 01 00 05, 20 02 00 0A, 00 22 18 20, AC with `s_valid` held high.
   - Writes: addr0=0x20010005, addr1=0x2002000A, addr2=0x00221820.
   - Then `done`=1 and `core_rst`=0.
   - After about 25 core cycles: r1=5, r2=10, r3=15.
2. **Empty image.** Stream 00 00, 00.
   - No `imem_we` pulses.
   - `done`=1, `core_rst`=0 after 3 accepted bytes.
3. **Bad checksum.** Same as scenario 1 but with checksum AD.
   - All three writes occur.
   - Then `err`=1, `done`=0, `core_rst` stays 1, `s_ready`=0.
4. **Oversize count.** With ADDR_W=8, stream 01 01.
   - `err`=1 at the edge accepting the second byte.
   - No writes.
   - Subsequent bytes are not accepted.
5. **Backpressure gaps.** Scenario 1 with `s_valid` deasserted for a random 0–3 cycles between bytes.
   - Identical write sequence and final state to scenario 1.
   - Each `imem_we` pulse lasts exactly one cycle.
6. **Reset mid-load.** Assert `rst` after 6 bytes of scenario 1.
   - Outputs return to reset values immediately, with `core_rst`=1.
   - A full replay of scenario 1 then succeeds with `done`=1.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake between the boot image source and the loader.
// A byte moves on a rising edge where s_valid and s_ready are both high.
interface imem_boot_loader_if;
    logic       s_valid;
    logic [7:0] s_byte;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_byte,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_byte,
        output s_ready
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a counted, checksummed image into imem
// and holds the core in reset until the image is verified.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   s,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [DATA_W-1:0]   imem_wdata,
    output logic                core_rst,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_live;
    logic [7:0]          r_nhi;
    logic [15:0]         r_n;
    logic [1:0]          r_bcnt;
    logic [ADDR_W:0]     r_wcnt;
    logic [7:0]          r_sum;
    logic [23:0]         r_shift;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_loading;
    logic                w_acc;
    logic [15:0]         w_n_new;
    logic [16:0]         w_cap;
    logic [ADDR_W:0]     w_wcnt_inc;
    logic                w_last_word;

    assign w_loading   = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) ||
                         (r_state == ST_DATA)   || (r_state == ST_CSUM);
    // r_live keeps s_ready low until the first edge after reset release
    assign s.s_ready   = r_live & w_loading;
    assign w_acc       = s.s_valid & s.s_ready;
    assign w_n_new     = {r_nhi, s.s_byte};
    assign w_cap       = 17'(1) << ADDR_W;
    assign w_wcnt_inc  = r_wcnt + 1'b1;
    assign w_last_word = (17'(w_wcnt_inc) == {1'b0, r_n});

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERR);
    assign core_rst   = (r_state != ST_DONE);

    // State register; reset forces core_rst high asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, advancing only on an accepted byte
    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            unique case (r_state)
                ST_HDR_HI: w_next = ST_HDR_LO;
                ST_HDR_LO: begin
                    if ({1'b0, w_n_new} > w_cap) begin
                        w_next = ST_ERR;
                    end else if (w_n_new == 16'd0) begin
                        w_next = ST_CSUM;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_bcnt == 2'd3 && w_last_word) begin
                        w_next = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    w_next = (s.s_byte == r_sum) ? ST_DONE : ST_ERR;
                end
                default: w_next = r_state;
            endcase
        end
    end

    // Header capture, word assembly, running sum and write strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live  <= 1'b0;
            r_nhi   <= '0;
            r_n     <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_sum   <= '0;
            r_shift <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_live <= 1'b1;
            r_we   <= 1'b0;
            if (w_acc) begin
                unique case (r_state)
                    ST_HDR_HI: r_nhi <= s.s_byte;
                    ST_HDR_LO: r_n   <= w_n_new;
                    ST_DATA: begin
                        r_sum <= r_sum + s.s_byte;
                        if (r_bcnt == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_wcnt[ADDR_W-1:0];
                            r_wdata <= {r_shift, s.s_byte};
                            r_wcnt  <= w_wcnt_inc;
                            r_bcnt  <= 2'd0;
                        end else begin
                            r_shift <= {r_shift[15:0], s.s_byte};
                            r_bcnt  <= r_bcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
